// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/sequencing side of the CPU datapath:
// sequencer states, the opcodes the sequencer itself reacts to, and the PC step.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [4:0] OP_HALT = 5'b11111;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_JMP  = 5'b10000;

    // Instructions are 16-bit words on a byte-addressed bus.
    localparam int PC_STEP = 2;

endpackage

// File: rtl/cpu_flag_reg.sv
// Four-bit C/V/S/Z flag register with write enable and synchronous reset.
module cpu_flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Hold the flags unless a write is enabled; reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'b0000;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_fetch_sequencer.sv
// Instruction fetch and sequencing unit: owns PC and IR, fetches over a
// req/ack handshake, presents the opcode to the controller, stalls LD/ST
// until data memory completes and holds the flag register.
module cpu_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ir,
    output logic [4:0]      opcode,
    output logic            instr_valid,
    output logic            mem_phase,
    input  logic            mem_done,
    input  logic            ldPC2,
    input  logic            ldPCz,
    input  logic [PC_W-1:0] pc_target,
    input  logic            flag_we,
    input  logic            alu_c,
    input  logic            alu_v,
    input  logic            alu_s,
    input  logic            alu_z,
    output logic            C,
    output logic            V,
    output logic            S,
    output logic            Z_det,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     ir_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [3:0]      flags;
    logic            flag_load;

    // ldPC2 selects the same sequential step as "no strobe", and the target
    // LSB is forced to zero, so neither influences the next PC.
    logic            unused_inputs;
    assign unused_inputs = ldPC2 ^ pc_target[0];

    assign pc_inc = pc + PC_W'(PC_STEP);

    // State, PC and IR registers; reset discards any in-flight ack or mem_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    // Next-state, PC update and IR capture.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_FETCH;
                    if (ldPCz) begin
                        pc_nxt = {pc_target[PC_W-1:1], 1'b0};
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase
    end

    // Flags only load during the single execute cycle of a flag-writing op.
    assign flag_load = (state == S_EXEC) && flag_we;

    cpu_flag_reg u_flag_reg (
        .clk (clk),
        .rst (rst),
        .we  (flag_load),
        .d   ({alu_c, alu_v, alu_s, alu_z}),
        .q   (flags)
    );

    assign {C, V, S, Z_det} = flags;

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign opcode      = ir[15:11];
    assign instr_valid = (state == S_EXEC);
    assign mem_phase   = (state == S_MEM);
    assign halted      = (state == S_HALT);

    logic unused_ok;
    assign unused_ok = unused_inputs;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Self-checking bench for cpu_fetch_sequencer: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural model of the instruction-level sequencing rules.
module tb_cpu_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic        instr_valid;
    logic        mem_phase;
    logic        mem_done;
    logic        ldPC2;
    logic        ldPCz;
    logic [15:0] pc_target;
    logic        flag_we;
    logic        alu_c, alu_v, alu_s, alu_z;
    logic        C, V, S, Z_det;
    logic [15:0] pc;
    logic        halted;

    cpu_fetch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .mem_phase   (mem_phase),
        .mem_done    (mem_done),
        .ldPC2       (ldPC2),
        .ldPCz       (ldPCz),
        .pc_target   (pc_target),
        .flag_we     (flag_we),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .alu_s       (alu_s),
        .alu_z       (alu_z),
        .C           (C),
        .V           (V),
        .S           (S),
        .Z_det       (Z_det),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Where the current instruction is in its life: waiting for the word,
    // executing, waiting for data memory, or stopped.
    localparam int WAIT_WORD = 0;
    localparam int EXECUTE   = 1;
    localparam int WAIT_DATA = 2;
    localparam int STOPPED   = 3;

    int          m_where = WAIT_WORD;
    int          m_pc    = 0;
    int          m_ir    = 0;
    logic [3:0]  m_flags = 4'b0;
    bit          chk_en  = 1'b0;

    always @(posedge clk) begin
        int op;
        if (rst) begin
            m_where = WAIT_WORD;
            m_pc    = 0;
            m_ir    = 0;
            m_flags = 4'b0;
        end else begin
            op = m_ir / 2048;
            if (m_where == WAIT_WORD) begin
                if (imem_ack) begin
                    m_ir    = int'(imem_rdata);
                    m_where = EXECUTE;
                end
            end else if (m_where == EXECUTE) begin
                if (flag_we) m_flags = {alu_c, alu_v, alu_s, alu_z};
                if (op == 31) begin
                    m_where = STOPPED;
                end else if (op == 14 || op == 15) begin
                    m_where = WAIT_DATA;
                end else begin
                    if (ldPCz) m_pc = int'(pc_target) - (int'(pc_target) % 2);
                    else       m_pc = (m_pc + 2) % 65536;
                    m_where = WAIT_WORD;
                end
            end else if (m_where == WAIT_DATA) begin
                if (mem_done) begin
                    m_pc    = (m_pc + 2) % 65536;
                    m_where = WAIT_WORD;
                end
            end
        end
        chk_en = 1'b1;
    end

    // Every cycle, compare the full output set against the model.
    always @(negedge clk) begin
        logic [63:0] act, exp;
        if (chk_en) begin
            act = {3'b0, imem_req, imem_addr, ir, opcode, instr_valid, mem_phase,
                   C, V, S, Z_det, pc, halted};
            exp = {3'b0, 1'(m_where == WAIT_WORD), 16'(m_pc), 16'(m_ir), 5'(m_ir / 2048),
                   1'(m_where == EXECUTE), 1'(m_where == WAIT_DATA),
                   m_flags, 16'(m_pc), 1'(m_where == STOPPED)};
            check("model_outputs", act, exp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        mem_done   = 1'b0;
        ldPC2      = 1'b0;
        ldPCz      = 1'b0;
        pc_target  = 16'h0000;
        flag_we    = 1'b0;
        {alu_c, alu_v, alu_s, alu_z} = 4'b0000;
    endtask

    // Deliver one word with a same-cycle ack; leaves the DUT in execute.
    task automatic fetch_word(input logic [15:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        check("rst_pc", pc, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_flags", {C, V, S, Z_det}, 4'b0000);
        check("rst_strobes", {instr_valid, mem_phase, halted}, 3'b000);
        rst = 1'b0;

        // Slow fetch: three wait cycles, then ack with word 0x0000.
        for (int i = 0; i < 4; i++) begin
            check("wait_req_addr", {imem_req, imem_addr}, {1'b1, 16'h0000});
            if (i == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'h0000;
            end
            tick();
        end
        imem_ack = 1'b0;
        check("exec_pulse", {instr_valid, imem_req}, 2'b10);
        tick();
        check("next_addr", {instr_valid, imem_req, imem_addr}, {2'b01, 16'h0002});

        // Flag-writing ALU op, then a non-writing op that must not disturb flags.
        fetch_word(16'h0800);
        flag_we = 1'b1; alu_c = 1'b1; alu_z = 1'b1;
        check("flags_not_yet", {C, Z_det}, 2'b00);
        tick();
        idle_inputs();
        check("flags_set", {C, V, S, Z_det}, 4'b1001);
        fetch_word(16'h0800);
        alu_v = 1'b1; alu_s = 1'b1;
        tick();
        idle_inputs();
        check("flags_held", {C, V, S, Z_det, pc}, {4'b1001, 16'h0006});

        // Jump with both strobes: target LSB dropped.
        fetch_word(16'h8000);
        ldPCz = 1'b1; ldPC2 = 1'b1; pc_target = 16'h0123;
        tick();
        idle_inputs();
        check("jump_addr", imem_addr, 16'h0122);

        // LD with a stray mem_done in execute, then four-cycle data wait.
        fetch_word(16'h7000);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ld_mem_phase", {mem_phase, pc}, {1'b1, 16'h0122});
            if (i == 3) mem_done = 1'b1;
            tick();
        end
        mem_done = 1'b0;
        check("ld_done_pc", {mem_phase, imem_req, pc}, {2'b01, 16'h0124});
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("done_in_fetch", {imem_req, pc}, {1'b1, 16'h0124});

        // Wrap at the top of the address space, then HALT.
        fetch_word(16'h8000);
        ldPCz = 1'b1; pc_target = 16'hFFFF;
        tick();
        idle_inputs();
        check("pc_top", pc, 16'hFFFE);
        fetch_word(16'h0000);
        tick();
        check("pc_wrap", imem_addr, 16'h0000);
        fetch_word(16'hF800);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("halt_hold", {halted, imem_req, instr_valid}, 3'b100);
            imem_ack = 1'b1; mem_done = 1'b1; imem_rdata = 16'h1234;
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt_reset", {halted, imem_req, pc, ir}, {2'b01, 16'h0000, 16'h0000});

        // Reset during a fetch wait, coincident with an ack.
        fetch_word(16'h0000);
        tick();
        tick();
        check("pre_rst_fetch", {imem_req, pc}, {1'b1, 16'h0002});
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hABCD;
        tick();
        rst = 1'b0; imem_ack = 1'b0;
        check("rst_fetch_wins", {ir, pc, instr_valid}, {16'h0000, 16'h0000, 1'b0});

        // Reset during a data wait, coincident with mem_done; flags must clear.
        fetch_word(16'h0800);
        flag_we = 1'b1; {alu_c, alu_v, alu_s, alu_z} = 4'b1111;
        tick();
        idle_inputs();
        fetch_word(16'h7800);
        tick();
        tick();
        check("pre_rst_mem", {mem_phase, C, V, S, Z_det}, 5'b11111);
        rst = 1'b1; mem_done = 1'b1;
        tick();
        rst = 1'b0; mem_done = 1'b0;
        check("rst_mem", {mem_phase, C, V, S, Z_det, pc, ir}, {5'b00000, 16'h0000, 16'h0000});
        tick();
        check("refetch_reset_pc", {imem_req, imem_addr}, {1'b1, 16'h0000});

        // Randomized traffic, checked by the per-cycle model compare.
        for (int i = 0; i < 4000; i++) begin
            imem_ack   = ($urandom_range(0, 1) == 1);
            imem_rdata = 16'($urandom());
            case ($urandom_range(0, 7))
                0: imem_rdata[15:11] = 5'b01110;
                1: imem_rdata[15:11] = 5'b01111;
                2: imem_rdata[15:11] = 5'b10000;
                default: ;
            endcase
            mem_done  = ($urandom_range(0, 2) == 0);
            ldPCz     = ($urandom_range(0, 3) == 0);
            ldPC2     = ($urandom_range(0, 3) == 0);
            pc_target = 16'($urandom());
            flag_we   = ($urandom_range(0, 1) == 1);
            {alu_c, alu_v, alu_s, alu_z} = 4'($urandom());
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
